// File: rtl/systolic_sequencer_2x2.sv
`timescale 1ns/1ps
// systolic_sequencer_2x2
// Sequences one 2x2 matrix product through the systolic array: clears the
// accumulators, drives the skewed operand selects for three feed steps,
// waits for the pipeline to drain, captures the four results and streams
// them out (c00, c01, c10, c11) over a registered valid/ready port.
module systolic_sequencer_2x2 #(
    parameter int unsigned DRAIN_CYCLES = 2   // legal range 1..7
) (
    input  logic               clk,
    input  logic               rst,           // asynchronous, active-low
    input  logic               start,
    input  logic               transpose_in,
    input  logic               relu_in,
    input  logic signed [15:0] c00,
    input  logic signed [15:0] c01,
    input  logic signed [15:0] c10,
    input  logic signed [15:0] c11,
    output logic               clear,
    output logic               data_valid,
    output logic [1:0]         a0_sel,
    output logic [1:0]         a1_sel,
    output logic [1:0]         b0_sel,
    output logic [1:0]         b1_sel,
    output logic               transpose,
    output logic               activation,
    output logic               busy,
    output logic [15:0]        out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               done
);

    // Select code that makes the array see a zero operand.
    localparam logic [1:0] SEL_ZERO   = 2'd2;
    // Last value of the drain counter before moving to capture.
    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_CAPTURE,
        S_OUT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  feed_step;      // 0..2 inside FEED
    logic [2:0]  drain_cnt;      // 0..DRAIN_CYCLES-1 inside DRAIN
    logic [1:0]  rd_ptr;         // index of the word currently on out_data
    logic [1:0]  rd_ptr_nxt;
    logic [15:0] result_buf [4];

    logic accept;                // start taken this cycle
    logic xfer;                  // a result word transfers this cycle
    logic last_xfer;             // the fourth word transfers this cycle

    // A start coinciding with the done pulse is dropped; IDLE takes it next cycle.
    assign accept     = (state == S_IDLE) && start && !done;
    assign xfer       = (state == S_OUT) && out_valid && out_ready;
    assign last_xfer  = xfer && (rd_ptr == 2'd3);
    assign rd_ptr_nxt = rd_ptr + 2'd1;
    assign busy       = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: registers use non-blocking (<=) so every flop samples the
        // pre-edge values; blocking here would create order-dependent races.
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept)                  state_nxt = S_CLEAR;
            S_CLEAR:                                state_nxt = S_FEED;
            S_FEED:    if (feed_step == 2'd2)       state_nxt = S_DRAIN;
            S_DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = S_CAPTURE;
            S_CAPTURE:                              state_nxt = S_OUT;
            S_OUT:     if (last_xfer)               state_nxt = S_IDLE;
            default:                                state_nxt = S_IDLE;
        endcase
    end

    // Array control decode: clear in CLEAR, skewed operand selects in FEED.
    always_comb begin
        clear      = 1'b0;
        data_valid = 1'b0;
        a0_sel     = SEL_ZERO;
        a1_sel     = SEL_ZERO;
        b0_sel     = SEL_ZERO;
        b1_sel     = SEL_ZERO;
        case (state)
            S_CLEAR: clear = 1'b1;
            S_FEED: begin
                data_valid = 1'b1;
                // Row/column 0 walk k = 0,1; row/column 1 lag one step behind.
                case (feed_step)
                    2'd0: begin
                        a0_sel = 2'd0;     a1_sel = SEL_ZERO;
                        b0_sel = 2'd0;     b1_sel = SEL_ZERO;
                    end
                    2'd1: begin
                        a0_sel = 2'd1;     a1_sel = 2'd0;
                        b0_sel = 2'd1;     b1_sel = 2'd0;
                    end
                    2'd2: begin
                        a0_sel = SEL_ZERO; a1_sel = 2'd1;
                        b0_sel = SEL_ZERO; b1_sel = 2'd1;
                    end
                    default: begin
                        a0_sel = SEL_ZERO; a1_sel = SEL_ZERO;
                        b0_sel = SEL_ZERO; b1_sel = SEL_ZERO;
                    end
                endcase
            end
            default: begin
                clear      = 1'b0;
                data_valid = 1'b0;
            end
        endcase
    end

    // Feed-step and drain counters; each runs only inside its own state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            feed_step <= 2'd0;
            drain_cnt <= 3'd0;
        end else begin
            feed_step <= (state == S_FEED)  ? feed_step + 2'd1 : 2'd0;
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 3'd1 : 3'd0;
        end
    end

    // Mode bits: captured on start acceptance, held until the next accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            transpose  <= 1'b0;
            activation <= 1'b0;
        end else if (accept) begin
            transpose  <= transpose_in;
            activation <= relu_in;
        end
    end

    // Result capture and registered output stream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the result buffer is only four words, so it is reset along
            // with the control state; a mid-run reset leaves no stale result.
            for (int i = 0; i < 4; i++) begin
                result_buf[i] <= '0;
            end
            rd_ptr    <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (state == S_CAPTURE) begin
            result_buf[0] <= c00;
            result_buf[1] <= c01;
            result_buf[2] <= c10;
            result_buf[3] <= c11;
            rd_ptr        <= 2'd0;
            out_valid     <= 1'b1;
            out_data      <= c00;
        end else if (xfer) begin
            rd_ptr <= rd_ptr_nxt;
            if (rd_ptr == 2'd3) begin
                out_valid <= 1'b0;
            end else begin
                out_data <= result_buf[rd_ptr_nxt];
            end
        end
    end

    // One-cycle completion pulse after the fourth word is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done <= 1'b0;
        end else begin
            done <= last_xfer;
        end
    end

endmodule

// File: tb/tb_systolic_sequencer_2x2.sv
`timescale 1ns/1ps
// Bench for systolic_sequencer_2x2: a behavioural 2x2 systolic array stub
// consumes the sequencer's selects; results are compared against a plain
// matrix-product reference and spec constants.
module tb_systolic_sequencer_2x2;

    localparam int DRAIN = 2;

    typedef logic signed [7:0] op_t;
    typedef op_t op4_t [4];
    typedef struct {
        op4_t        a;
        op4_t        b;
        bit          tr;
        bit          rl;
        logic [15:0] exp_w [4];
    } vec_t;

    logic clk = 1'b0;
    logic rst, start, transpose_in, relu_in, out_ready;
    logic signed [15:0] c00, c01, c10, c11;
    logic clear, data_valid, transpose, activation, busy, out_valid, done;
    logic [1:0] a0_sel, a1_sel, b0_sel, b1_sel;
    logic [15:0] out_data;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    systolic_sequencer_2x2 #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst), .start(start),
        .transpose_in(transpose_in), .relu_in(relu_in),
        .c00(c00), .c01(c01), .c10(c10), .c11(c11),
        .clear(clear), .data_valid(data_valid),
        .a0_sel(a0_sel), .a1_sel(a1_sel), .b0_sel(b0_sel), .b1_sel(b1_sel),
        .transpose(transpose), .activation(activation), .busy(busy),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .done(done)
    );

    // ---------------- operand memories and systolic array stub -------------
    op4_t mem_a;   // A row-major: A[i][k] = mem_a[2i+k]
    op4_t mem_b;   // B row-major: B[k][j] = mem_b[2k+j]

    function automatic logic signed [15:0] a_val(input int i, input logic [1:0] sel);
        if (!data_valid || sel > 2'd1) return 16'sd0;
        return 16'(mem_a[2*i + int'(sel)]);
    endfunction

    function automatic logic signed [15:0] b_val(input int j, input logic [1:0] sel);
        if (!data_valid || sel > 2'd1) return 16'sd0;
        if (transpose) return 16'(mem_b[2*j + int'(sel)]);
        return 16'(mem_b[2*int'(sel) + j]);
    endfunction

    logic signed [15:0] acc [4];
    logic signed [15:0] a_r00, a_r10, b_r00, b_r01;

    always @(posedge clk or negedge rst) begin
        logic signed [15:0] a_in0, a_in1, b_in0, b_in1;
        if (!rst) begin
            for (int i = 0; i < 4; i++) acc[i] <= 16'sd0;
            a_r00 <= 0; a_r10 <= 0; b_r00 <= 0; b_r01 <= 0;
        end else if (clear) begin
            for (int i = 0; i < 4; i++) acc[i] <= 16'sd0;
            a_r00 <= 0; a_r10 <= 0; b_r00 <= 0; b_r01 <= 0;
        end else begin
            a_in0 = a_val(0, a0_sel);
            a_in1 = a_val(1, a1_sel);
            b_in0 = b_val(0, b0_sel);
            b_in1 = b_val(1, b1_sel);
            acc[0] <= acc[0] + a_in0 * b_in0;
            acc[1] <= acc[1] + a_r00 * b_in1;
            acc[2] <= acc[2] + a_in1 * b_r00;
            acc[3] <= acc[3] + a_r10 * b_r01;
            a_r00 <= a_in0; b_r00 <= b_in0;
            a_r10 <= a_in1; b_r01 <= b_in1;
        end
    end

    assign c00 = (activation && acc[0][15]) ? 16'sd0 : acc[0];
    assign c01 = (activation && acc[1][15]) ? 16'sd0 : acc[1];
    assign c10 = (activation && acc[2][15]) ? 16'sd0 : acc[2];
    assign c11 = (activation && acc[3][15]) ? 16'sd0 : acc[3];

    // ---------------- reference model and helpers --------------------------
    function automatic void model(input op4_t a, input op4_t b, input bit tr,
                                  input bit rl, output logic [15:0] w [4]);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                int s = 0;
                for (int k = 0; k < 2; k++) begin
                    int bv = tr ? int'(b[2*j+k]) : int'(b[2*k+j]);
                    s += int'(a[2*i+k]) * bv;
                end
                if (rl && s < 0) s = 0;
                w[2*i+j] = 16'(s);
            end
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // mode 0: out_ready held high; 1: fixed backpressure pattern plus a start
    // pulse during OUT; 2: random out_ready. Returns at the negedge of the
    // cycle in which done is seen (or after the cycle budget expires).
    task automatic run_product(input op4_t a, input op4_t b, input bit tr, input bit rl,
                               input int mode, input bit chk_seq,
                               output logic [15:0] got [4], output int n_got,
                               output int done_cyc);
        bit pat [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int cyc = 1, pat_i = 0, last_xfer = -10;
        bit seen_done = 0, prev_stall = 0, mode_ok = 1, r;
        logic [15:0] prev_data = '0;
        logic [9:0] exp_ctl;
        logic [1:0] ea0, ea1;
        n_got = 0;
        done_cyc = -1;
        for (int i = 0; i < 4; i++) got[i] = '0;
        mem_a = a;
        mem_b = b;
        @(negedge clk);
        transpose_in = tr; relu_in = rl; start = 1'b1; out_ready = 1'b0;
        @(negedge clk);                 // cycle 1
        start = 1'b0;
        while (!seen_done && cyc < 200) begin
            if (chk_seq && cyc <= 5) begin
                ea0 = (cyc == 2) ? 2'd0 : (cyc == 3) ? 2'd1 : 2'd2;
                ea1 = (cyc == 3) ? 2'd0 : (cyc == 4) ? 2'd1 : 2'd2;
                exp_ctl = {cyc == 1, cyc >= 2 && cyc <= 4, ea0, ea1, ea0, ea1};
                check($sformatf("ctl_cycle%0d", cyc),
                      64'({clear, data_valid, a0_sel, a1_sel, b0_sel, b1_sel}), 64'(exp_ctl));
            end
            if (cyc == 1) check("busy_rises_cycle1", 64'(busy), 64'd1);
            if (prev_stall) begin
                check("stall_valid_held", 64'(out_valid), 64'd1);
                check("stall_data_held", 64'(out_data), 64'(prev_data));
            end
            if (done) begin
                seen_done = 1;
                done_cyc  = cyc;
                check("done_after_last_xfer", 64'(cyc), 64'(last_xfer + 1));
                check("busy_low_with_done", 64'(busy), 64'd0);
            end else begin
                if (transpose !== tr || activation !== rl) mode_ok = 0;
                case (mode)
                    0: r = 1'b1;
                    1: begin
                        r = 1'b0;
                        start = 1'b0;
                        if (out_valid) begin
                            if (pat_i == 0) start = 1'b1;   // must be ignored
                            r = (pat_i < 8) ? pat[pat_i] : 1'b1;
                            pat_i++;
                        end
                    end
                    default: r = 1'($urandom_range(0, 1));
                endcase
                out_ready = r;
                if (out_valid && r) begin
                    if (n_got < 4) got[n_got] = out_data;
                    n_got++;
                    last_xfer = cyc;
                end
                prev_stall = out_valid && !r;
                prev_data  = out_data;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        out_ready = 1'b0;
        check("done_seen_in_budget", 64'(seen_done), 64'd1);
        check("mode_bits_held", 64'(mode_ok), 64'd1);
        check("word_count", 64'(n_got), 64'd4);
    endtask

    // ---------------- test sequence ----------------------------------------
    vec_t tbl [4];

    initial begin
        logic [15:0] got [4];
        logic [15:0] exp_w [4];
        int n_got, done_cyc, dcount;
        op4_t ra, rb;
        bit rtr, rrl;

        tbl[0].a = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        tbl[0].b = '{8'sd5, 8'sd6, 8'sd7, 8'sd8};
        tbl[0].tr = 0; tbl[0].rl = 0;
        tbl[0].exp_w = '{16'd19, 16'd22, 16'd43, 16'd50};
        tbl[1].a = tbl[0].a; tbl[1].b = tbl[0].b;
        tbl[1].tr = 1; tbl[1].rl = 0;
        tbl[1].exp_w = '{16'd17, 16'd23, 16'd39, 16'd53};
        tbl[2].a = '{8'shFF, 8'sd0, 8'sd0, 8'sd1};
        tbl[2].b = '{8'sd3, 8'sd0, 8'sd0, 8'shFE};
        tbl[2].tr = 0; tbl[2].rl = 0;
        tbl[2].exp_w = '{16'hFFFD, 16'h0000, 16'h0000, 16'hFFFE};
        tbl[3].a = tbl[2].a; tbl[3].b = tbl[2].b;
        tbl[3].tr = 0; tbl[3].rl = 1;
        tbl[3].exp_w = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};

        rst = 1'b0; start = 1'b0; transpose_in = 1'b0; relu_in = 1'b0; out_ready = 1'b0;
        mem_a = tbl[0].a; mem_b = tbl[0].b;
        #12;
        check("reset_values",
              64'({clear, data_valid, a0_sel, a1_sel, b0_sel, b1_sel, transpose,
                   activation, busy, out_valid, done, out_data}),
              64'({1'b0, 1'b0, 2'd2, 2'd2, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0}));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Table-driven products.
        for (int t = 0; t < 4; t++) begin
            run_product(tbl[t].a, tbl[t].b, tbl[t].tr, tbl[t].rl, 0, t == 0, got, n_got, done_cyc);
            for (int w = 0; w < 4; w++)
                check($sformatf("vec%0d_word%0d", t, w), 64'(got[w]), 64'(tbl[t].exp_w[w]));
            if (t == 0) begin
                check("done_cycle_min", 64'(done_cyc), 64'(10 + DRAIN));
                // start in the done cycle is ignored, then taken next cycle
                start = 1'b1;
                @(negedge clk);
                check("start_on_done_ignored", 64'({busy, clear}), 64'b00);
                @(negedge clk);
                start = 1'b0;
                check("start_after_done_taken", 64'({busy, clear}), 64'b11);
                out_ready = 1'b1;
                dcount = 0;
                for (int c = 0; c < 40 && dcount == 0; c++) begin
                    @(negedge clk);
                    if (done) dcount++;
                end
                out_ready = 1'b0;
                check("restart_completes", 64'(dcount), 64'd1);
                @(negedge clk);
            end
        end

        // Backpressure with a start pulse during OUT.
        run_product(tbl[0].a, tbl[0].b, 1'b0, 1'b0, 1, 1'b0, got, n_got, done_cyc);
        for (int w = 0; w < 4; w++)
            check($sformatf("bp_word%0d", w), 64'(got[w]), 64'(tbl[0].exp_w[w]));
        @(negedge clk);
        check("done_one_cycle", 64'({done, busy}), 64'b00);
        @(negedge clk);
        check("start_in_out_not_queued", 64'({busy, clear}), 64'b00);

        // Reset in FEED step 1 (cycle 3).
        mem_a = tbl[0].a; mem_b = tbl[0].b;
        transpose_in = 1'b1; relu_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("feed_step1_before_reset", 64'({data_valid, a0_sel, a1_sel}), 64'({1'b1, 2'd1, 2'd0}));
        #2 rst = 1'b0;
        #1;
        check("reset_midrun_values",
              64'({clear, data_valid, a0_sel, a1_sel, b0_sel, b1_sel, transpose,
                   activation, busy, out_valid, done, out_data}),
              64'({1'b0, 1'b0, 2'd2, 2'd2, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0}));
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        out_ready = 1'b0;
        check("no_done_after_reset", 64'(dcount), 64'd0);
        run_product(tbl[0].a, tbl[0].b, 1'b0, 1'b0, 0, 1'b0, got, n_got, done_cyc);
        for (int w = 0; w < 4; w++)
            check($sformatf("post_reset_word%0d", w), 64'(got[w]), 64'(tbl[0].exp_w[w]));
        @(negedge clk);

        // Randomized products against the reference model.
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 4; i++) begin
                ra[i] = 8'($urandom);
                rb[i] = 8'($urandom);
            end
            rtr = 1'($urandom_range(0, 1));
            rrl = 1'($urandom_range(0, 1));
            model(ra, rb, rtr, rrl, exp_w);
            run_product(ra, rb, rtr, rrl, 2, 1'b0, got, n_got, done_cyc);
            for (int w = 0; w < 4; w++)
                check($sformatf("rand%0d_word%0d", n, w), 64'(got[w]), 64'(exp_w[w]));
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
